// File: rtl/pmu_counter_bank.sv
// Bank of event counters with config preload, sticky wrap flags and a held,
// maskable overflow interrupt. Events are registered once before counting.
module pmu_counter_bank #(
   parameter int REG_WIDTH  = 32,
   parameter int N_COUNTERS = 9
) (
   input  logic                                   clk_i,
   input  logic                                   rstn_i,
   input  logic                                   softrst_i,
   input  logic                                   en_i,
   input  logic [N_COUNTERS-1:0]                  events_i,
   input  logic [N_COUNTERS-1:0]                  we_i,
   input  logic [N_COUNTERS-1:0][REG_WIDTH-1:0]   wdata_i,
   input  logic [N_COUNTERS-1:0]                  overflow_mask_i,
   output logic [N_COUNTERS-1:0][REG_WIDTH-1:0]   counter_value_o,
   output logic [N_COUNTERS-1:0]                  overflow_o,
   output logic                                   intr_overflow_o
);

   logic [N_COUNTERS-1:0]                r_ev_q;
   logic [N_COUNTERS-1:0][REG_WIDTH-1:0] r_cnt;
   logic [N_COUNTERS-1:0]                r_ovf;
   logic                                 r_intr_hold;
   logic [REG_WIDTH:0]                   w_inc [N_COUNTERS];
   logic                                 w_intr_raw;

   // Modulo increment; the extra top bit is the wrap carry.
   function automatic logic [REG_WIDTH:0] inc_wrap(input logic [REG_WIDTH-1:0] v);
      return {1'b0, v} + {{REG_WIDTH{1'b0}}, 1'b1};
   endfunction

   always_comb begin
      for (int n = 0; n < N_COUNTERS; n++) begin
         w_inc[n] = inc_wrap(r_cnt[n]);
      end
   end

   // Input stage: not gated by en_i so a strobe is never half-captured.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_ev_q <= '0;
      end else if (softrst_i) begin
         r_ev_q <= '0;
      end else begin
         r_ev_q <= events_i;
      end
   end

   // Count stage: write beats a pending event; the wrap sets the sticky flag.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_cnt <= '0;
         r_ovf <= '0;
      end else if (softrst_i) begin
         r_cnt <= '0;
         r_ovf <= '0;
      end else begin
         for (int n = 0; n < N_COUNTERS; n++) begin
            if (we_i[n]) begin
               r_cnt[n] <= wdata_i[n];
            end else if (en_i && r_ev_q[n]) begin
               r_cnt[n] <= w_inc[n][REG_WIDTH-1:0];
               if (w_inc[n][REG_WIDTH]) begin
                  r_ovf[n] <= 1'b1;
               end
            end
         end
      end
   end

   assign w_intr_raw = |(r_ovf & overflow_mask_i);

   // The hold keeps the interrupt up even if software later clears the mask.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_intr_hold <= 1'b0;
      end else if (softrst_i) begin
         r_intr_hold <= 1'b0;
      end else if (w_intr_raw) begin
         r_intr_hold <= 1'b1;
      end
   end

   assign counter_value_o = r_cnt;
   assign overflow_o      = r_ovf;
   assign intr_overflow_o = w_intr_raw | r_intr_hold;

endmodule

// File: tb/tb_pmu_counter_bank.sv
// Bench for pmu_counter_bank: directed vector table, hand-written corner
// sequences and randomized traffic against a behavioural reference model.
module tb_pmu_counter_bank;
   localparam int W = 32;
   localparam int N = 9;

   logic                    clk = 1'b0;
   logic                    rstn, softrst, en;
   logic [N-1:0]            ev, we, mask;
   logic [N-1:0][W-1:0]     wdata;
   logic [N-1:0][W-1:0]     cv;
   logic [N-1:0]            ovf;
   logic                    intr;

   int pass_cnt = 0;
   int total_cnt = 0;

   // Reference model state
   logic [W-1:0] m_cnt [N];
   logic [N-1:0] m_ovf, m_pend;
   logic         m_hold;

   pmu_counter_bank #(.REG_WIDTH(W), .N_COUNTERS(N)) dut (
      .clk_i(clk), .rstn_i(rstn), .softrst_i(softrst), .en_i(en),
      .events_i(ev), .we_i(we), .wdata_i(wdata), .overflow_mask_i(mask),
      .counter_value_o(cv), .overflow_o(ovf), .intr_overflow_o(intr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
      total_cnt++;
      if (act === exp_v) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
   endtask

   task automatic model_reset();
      for (int n = 0; n < N; n++) m_cnt[n] = '0;
      m_ovf = '0; m_pend = '0; m_hold = 1'b0;
   endtask

   // One clock edge of the spec's rules, using the inputs present before it.
   task automatic model_edge();
      longint unsigned nx;
      if (!rstn) begin
         model_reset();
         return;
      end
      if (softrst) begin
         model_reset();
         return;
      end
      if ((m_ovf & mask) != '0) m_hold = 1'b1;
      for (int n = 0; n < N; n++) begin
         if (we[n]) m_cnt[n] = wdata[n];
         else if (en && m_pend[n]) begin
            nx = longint'(m_cnt[n]) + 1;
            if (nx == (64'd1 << W)) begin
               m_cnt[n] = '0;
               m_ovf[n] = 1'b1;
            end else m_cnt[n] = nx[W-1:0];
         end
      end
      m_pend = ev;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string nm);
      for (int n = 0; n < N; n++) chk($sformatf("%s_cnt%0d", nm, n), 64'(cv[n]), 64'(m_cnt[n]));
      chk({nm, "_ovf"}, 64'(ovf), 64'(m_ovf));
      chk({nm, "_intr"}, 64'(intr), 64'(((m_ovf & mask) != '0) || m_hold));
   endtask

   task automatic idle_inputs();
      softrst = 1'b0; ev = '0; we = '0; wdata = '0;
   endtask

   task automatic do_softrst();
      idle_inputs();
      softrst = 1'b1;
      tick();
      softrst = 1'b0;
   endtask

   typedef struct {
      logic         en;
      logic [N-1:0] ev;
      logic [N-1:0] we;
      logic [W-1:0] wd;
      logic         sr;
      logic [W-1:0] e0;
      logic [W-1:0] e3;
      logic [W-1:0] e5;
   } vec_t;

   vec_t tbl [21];

   initial begin
      // Directed table: values expected on counters 0, 3 and 5 after each edge
      tbl[0]  = '{1'b1, 9'h001, 9'h000, 32'd0,   1'b0, 32'd0, 32'd0,   32'd0};
      tbl[1]  = '{1'b1, 9'h001, 9'h000, 32'd0,   1'b0, 32'd1, 32'd0,   32'd0};
      tbl[2]  = '{1'b1, 9'h001, 9'h000, 32'd0,   1'b0, 32'd2, 32'd0,   32'd0};
      tbl[3]  = '{1'b1, 9'h001, 9'h000, 32'd0,   1'b0, 32'd3, 32'd0,   32'd0};
      tbl[4]  = '{1'b1, 9'h001, 9'h000, 32'd0,   1'b0, 32'd4, 32'd0,   32'd0};
      tbl[5]  = '{1'b1, 9'h008, 9'h000, 32'd0,   1'b0, 32'd5, 32'd0,   32'd0};
      tbl[6]  = '{1'b1, 9'h000, 9'h000, 32'd0,   1'b0, 32'd5, 32'd1,   32'd0};
      tbl[7]  = '{1'b1, 9'h000, 9'h000, 32'd0,   1'b0, 32'd5, 32'd1,   32'd0};
      tbl[8]  = '{1'b0, 9'h020, 9'h000, 32'd0,   1'b0, 32'd5, 32'd1,   32'd0};
      tbl[9]  = '{1'b0, 9'h020, 9'h000, 32'd0,   1'b0, 32'd5, 32'd1,   32'd0};
      tbl[10] = '{1'b0, 9'h020, 9'h000, 32'd0,   1'b0, 32'd5, 32'd1,   32'd0};
      tbl[11] = '{1'b0, 9'h020, 9'h000, 32'd0,   1'b0, 32'd5, 32'd1,   32'd0};
      tbl[12] = '{1'b0, 9'h020, 9'h000, 32'd0,   1'b0, 32'd5, 32'd1,   32'd0};
      tbl[13] = '{1'b0, 9'h000, 9'h000, 32'd0,   1'b0, 32'd5, 32'd1,   32'd0};
      tbl[14] = '{1'b1, 9'h000, 9'h000, 32'd0,   1'b0, 32'd5, 32'd1,   32'd0};
      tbl[15] = '{1'b1, 9'h000, 9'h028, 32'd100, 1'b0, 32'd5, 32'd100, 32'd100};
      tbl[16] = '{1'b1, 9'h020, 9'h000, 32'd0,   1'b0, 32'd5, 32'd100, 32'd100};
      tbl[17] = '{1'b1, 9'h000, 9'h020, 32'd7,   1'b0, 32'd5, 32'd100, 32'd7};
      tbl[18] = '{1'b1, 9'h000, 9'h000, 32'd0,   1'b0, 32'd5, 32'd100, 32'd7};
      tbl[19] = '{1'b1, 9'h1FF, 9'h000, 32'd0,   1'b1, 32'd0, 32'd0,   32'd0};
      tbl[20] = '{1'b1, 9'h000, 9'h000, 32'd0,   1'b0, 32'd0, 32'd0,   32'd0};

      rstn = 1'b0; en = 1'b0; mask = '0;
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rstn = 1'b1;
      tick();
      check_all("idle");

      for (int i = 0; i < 21; i++) begin
         en = tbl[i].en; ev = tbl[i].ev; we = tbl[i].we; softrst = tbl[i].sr;
         for (int n = 0; n < N; n++) wdata[n] = tbl[i].wd;
         tick();
         chk($sformatf("tbl%0d_cnt0", i), 64'(cv[0]), 64'(tbl[i].e0));
         chk($sformatf("tbl%0d_cnt3", i), 64'(cv[3]), 64'(tbl[i].e3));
         chk($sformatf("tbl%0d_cnt5", i), 64'(cv[5]), 64'(tbl[i].e5));
         check_all($sformatf("tbl%0d", i));
      end

      // Wrap with interrupt enabled, then mask cleared, then soft reset
      idle_inputs(); en = 1'b1; mask = 9'h004;
      we[2] = 1'b1; wdata[2] = 32'hFFFF_FFFE;
      tick();
      chk("wrap_preload", 64'(cv[2]), 64'hFFFF_FFFE);
      idle_inputs(); ev[2] = 1'b1;
      tick();
      tick();
      chk("wrap_ones", 64'(cv[2]), 64'hFFFF_FFFF);
      ev = '0;
      tick();
      chk("wrap_zero", 64'(cv[2]), 64'h0);
      chk("wrap_ovf", 64'(ovf[2]), 64'h1);
      chk("wrap_intr", 64'(intr), 64'h1);
      tick();
      mask = '0;
      #1;
      chk("wrap_mask_clr_intr", 64'(intr), 64'h1);
      chk("wrap_mask_clr_ovf", 64'(ovf[2]), 64'h1);
      check_all("wrap");
      do_softrst();
      chk("wrap_srst_ovf", 64'(ovf), 64'h0);
      chk("wrap_srst_intr", 64'(intr), 64'h0);

      // Masked overflow, late unmask, then write of 0 keeps the flag
      idle_inputs(); mask = '0;
      we[1] = 1'b1; wdata[1] = 32'hFFFF_FFFF;
      tick();
      idle_inputs(); ev[1] = 1'b1;
      tick();
      ev = '0;
      tick();
      chk("mask_cnt", 64'(cv[1]), 64'h0);
      chk("mask_ovf", 64'(ovf[1]), 64'h1);
      chk("mask_intr_off", 64'(intr), 64'h0);
      mask = 9'h002;
      #1;
      chk("mask_late_intr", 64'(intr), 64'h1);
      we[1] = 1'b1; wdata[1] = '0;
      tick();
      chk("wr0_ovf_kept", 64'(ovf[1]), 64'h1);
      check_all("mask");
      do_softrst();
      mask = '0;

      // Write/event collision: write arriving on the counting edge wins
      idle_inputs();
      we[4] = 1'b1; wdata[4] = 32'd10;
      tick();
      idle_inputs(); ev[4] = 1'b1;
      tick();
      idle_inputs(); we[4] = 1'b1; wdata[4] = 32'd100;
      tick();
      chk("collide_cnt4", 64'(cv[4]), 64'd100);
      idle_inputs();
      tick();
      chk("collide_hold", 64'(cv[4]), 64'd100);

      // Soft reset racing events on every counter
      idle_inputs(); ev = '1;
      tick();
      tick();
      softrst = 1'b1;
      tick();
      softrst = 1'b0; ev = '1;
      for (int n = 0; n < N; n++) chk($sformatf("srst_zero%0d", n), 64'(cv[n]), 64'h0);
      tick();
      ev = '0;
      for (int n = 0; n < N; n++) chk($sformatf("srst_noinc%0d", n), 64'(cv[n]), 64'h0);
      tick();
      for (int n = 0; n < N; n++) chk($sformatf("srst_next%0d", n), 64'(cv[n]), 64'h1);

      // Asynchronous reset mid-count with events still toggling
      ev = N'($urandom);
      tick();
      #3;
      rstn = 1'b0;
      model_reset();
      #1;
      check_all("arst_async");
      for (int k = 0; k < 3; k++) begin
         ev = N'($urandom);
         tick();
         check_all("arst_hold");
      end
      rstn = 1'b1;
      ev = 9'h040;
      tick();
      ev = '0;
      chk("arst_first_edge", 64'(cv[6]), 64'h0);
      tick();
      chk("arst_second_edge", 64'(cv[6]), 64'h1);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         ev = N'($urandom);
         en = ($urandom_range(9) != 0);
         softrst = ($urandom_range(59) == 0);
         we = '0;
         for (int n = 0; n < N; n++) begin
            if ($urandom_range(9) == 0) begin
               we[n] = 1'b1;
               wdata[n] = ($urandom_range(1) == 1) ? (32'hFFFF_FFF8 | W'($urandom_range(7)))
                                                   : W'($urandom);
            end
         end
         if ($urandom_range(19) == 0) mask = N'($urandom);
         tick();
         check_all($sformatf("rnd%0d", i));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/pmu_counter_bank.md
# pmu_counter_bank

Bank of N event counters that turns per-cycle event strobes into the counter values consumed by the per-core quota checker. It sits between the event-routing crossbar and the quota/overflow logic. The configuration interface can preload any counter, and each counter has a sticky overflow flag. A masked overflow interrupt is raised and held until soft reset.

## Interface
- REG_WIDTH, 32, width of each counter.
- N_COUNTERS, 9, number of counters (≥1).
- clk_i  in  1  single clock, rising edge.
- rstn_i  in  1  asynchronous reset, active low.
- softrst_i  in  1  synchronous soft reset from config registers, active high.
- en_i  in  1  global counting enable.
- events_i  in  N_COUNTERS  event strobe per counter; one event per high cycle.
- we_i  in  N_COUNTERS  per-counter write enable from config interface.
- wdata_i  in  REG_WIDTH x N_COUNTERS  value loaded into counter n when we_i[n]=1.
- overflow_mask_i  in  N_COUNTERS  interrupt enable per counter.
- counter_value_o  out  REG_WIDTH x N_COUNTERS  current counter values, registered.
- overflow_o  out  N_COUNTERS  sticky per-counter wrap flags.
- intr_overflow_o  out  1  overflow interrupt.

## Operation
- Input stage: events_i is registered into ev_q every cycle.
  - ev_q is cleared by rstn_i and by softrst_i.
  - ev_q is not gated by en_i.
- Count stage, per counter n, in priority order:
  1. softrst_i: cnt[n] is set to 0, ovf[n] to 0, ev_q to 0.
  2. we_i[n]: cnt[n] is set to wdata_i[n]; a pending ev_q[n] is dropped; ovf[n] is unchanged.
  3. en_i && ev_q[n]: cnt[n] is set to cnt[n]+1 modulo 2^REG_WIDTH.
     - If cnt[n] was all ones, it wraps to 0 and ovf[n] is set to 1.
  4. Otherwise cnt[n] holds.
- ovf[n] is sticky. Only rstn_i or softrst_i clears it. Writes never clear it.
- Interrupt:
  - intr_hold is set to 1 when |(ovf & overflow_mask_i) is 1.
  - intr_hold is cleared only by rstn_i or softrst_i.
  - intr_overflow_o = |(ovf & overflow_mask_i) | intr_hold.
  - Clearing a mask bit after the interrupt fires does not drop intr_overflow_o.
- Counters are independent. Any combination of we_i and events in the same cycle is legal.
- en_i=0 freezes all counters. Writes and soft reset still take effect.
- Reset values (rstn_i low): counter_value_o all 0, overflow_o 0, intr_overflow_o 0, ev_q 0, intr_hold 0.

## Timing
- Event latency:
  - events_i[n] high in cycle t (sampled at edge t) increments counter_value_o[n] at edge t+1.
  - The new value is visible in cycle t+1 after that edge, i.e. 2 edges from strobe to value.
- Write latency: we_i[n] at edge t makes wdata_i[n] visible on counter_value_o[n] after edge t.
- Write/event collision: an event sampled at edge t-1 meets a write at edge t. The write wins and that event is lost.
- Overflow: the wrap edge sets overflow_o[n] and updates counter_value_o[n] to 0 on the same edge.
  - intr_overflow_o rises combinationally in the same cycle if the mask bit is set.
  - intr_hold follows one edge later.
- Mask rising while ovf[n] is already 1: intr_overflow_o rises in the same cycle, combinationally.
- softrst_i at edge t: all outputs read 0 after edge t.
  - Events sampled at edge t are discarded.
  - Events sampled at edge t+1 count normally.
- rstn_i asserted mid-count clears everything asynchronously. After deassertion, the first sampled event appears 2 edges later.

## Test plan
- Reset/idle:
  - Stimulus: assert rstn_i=0 mid-run with random events, then release.
  - Required: all outputs 0 while in reset. The first event after release makes counter_value_o[n]=1 two edges later.
- Basic count:
  - Stimulus: en_i=1; hold events_i[0] high for 5 cycles, then low; pulse events_i[3] once.
  - Required: cnt0 reaches 5 and stays there; cnt3=1; all other counters stay 0. With en_i=0 for the same stimulus, all counters stay 0.
- Wrap and interrupt:
  - Stimulus: REG_WIDTH=32; write cnt2=0xFFFFFFFE; overflow_mask_i[2]=1; send 2 events.
  - Required: cnt2 goes 0xFFFFFFFF then 0x00000000. overflow_o[2]=1 and intr_overflow_o=1 on the wrap edge. Both stay 1 after the mask is cleared; softrst_i clears both.
- Masked overflow:
  - Stimulus: wrap cnt1 with overflow_mask_i[1]=0.
  - Required: overflow_o[1]=1 and intr_overflow_o=0. Setting the mask to 1 later raises intr_overflow_o in the same cycle.
- Write/event collision:
  - Stimulus: cnt4=10; event on cycle t; we_i[4] with wdata=100 at edge t+1.
  - Required: cnt4=100, not 101. A write of 0 to an overflowed counter leaves overflow_o set.
- Soft reset race:
  - Stimulus: events on all counters plus softrst_i in the same cycle.
  - Required: all counters 0 and no increment on the following edge. Events in the cycle after softrst_i deasserts count normally.
